// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshake and LCD bus bundle for lcd_bus_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters and the LCD side.
interface lcd_bus_arbiter_if;
  logic       valid0;
  logic       rs0;
  logic [7:0] data0;
  logic       ready0;
  logic       valid1;
  logic       rs1;
  logic [7:0] data1;
  logic       ready1;
  logic [7:0] data;
  logic       RS;
  logic       RW;
  logic       EN;
  logic       busy;
  logic       init_done;
  logic       grant;

  modport slave (
    input  valid0, rs0, data0, valid1, rs1, data1,
    output ready0, ready1, data, RS, RW, EN, busy, init_done, grant
  );

  modport master (
    output valid0, rs0, data0, valid1, rs1, data1,
    input  ready0, ready1, data, RS, RW, EN, busy, init_done, grant
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// HD44780-style character LCD bus owner.
// It runs the power-up delay and the fixed init sequence, then shares the
// write-only bus between two requesters with round-robin arbitration.
// It generates the EN strobe and the post-write settle time.
module lcd_bus_arbiter #(
  parameter int EN_HIGH_CYC   = 25,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int LONG_WAIT_CYC = 100000,
  parameter int PWRUP_CYC     = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  lcd_bus_arbiter_if.slave   bus
);

  localparam int MAX_AB  = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
  localparam int MAX_CD  = (LONG_WAIT_CYC > PWRUP_CYC) ? LONG_WAIT_CYC : PWRUP_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_PWRUP   = 3'd0,
    S_INIT_LD = 3'd1,
    S_EN_HI   = 3'd2,
    S_EN_LO   = 3'd3,
    S_IDLE    = 3'd4
  } state_t;

  // Fixed init sequence: 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] init_rom(input logic [1:0] k);
    case (k)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (!rs) && (d[7:2] == 6'd0) && (d != 8'd0);
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  cnt_t       r_cnt;
  cnt_t       w_limit;
  logic       w_cnt_last;
  logic [1:0] r_rom_idx;
  logic       w_rom_more;
  logic [7:0] r_data;
  logic       r_rs;
  logic       r_init_done;
  logic       r_grant;
  logic       r_rr;
  logic       w_sel0;
  logic       w_sel1;
  logic       w_ready0;
  logic       w_ready1;
  logic       w_accept;
  logic       w_en;
  logic       w_busy;

  // With a single valid that requester wins. With both valid, the rr pointer decides.
  assign w_sel0   = bus.valid0 & (~bus.valid1 | (r_rr == 1'b0));
  assign w_sel1   = bus.valid1 & (~bus.valid0 | (r_rr == 1'b1));
  assign w_accept = w_ready0 | w_ready1;

  // More ROM bytes remain only during init and before the last entry.
  assign w_rom_more = (!r_init_done) && (r_rom_idx != 2'd3);

  // Per-state dwell length; the counter restarts on entry, so last = limit-1
  always_comb begin
    w_limit = cnt_t'(1);
    case (r_state)
      S_PWRUP: w_limit = cnt_t'(PWRUP_CYC);
      S_EN_HI: w_limit = cnt_t'(EN_HIGH_CYC);
      S_EN_LO: w_limit = is_long_cmd(r_rs, r_data) ? cnt_t'(LONG_WAIT_CYC)
                                                   : cnt_t'(CMD_WAIT_CYC);
      default: w_limit = cnt_t'(1);
    endcase
  end

  assign w_cnt_last = (r_cnt == (w_limit - cnt_t'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PWRUP;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PWRUP:   if (w_cnt_last) w_state_nxt = S_INIT_LD;
      S_INIT_LD: w_state_nxt = S_EN_HI;
      S_EN_HI:   if (w_cnt_last) w_state_nxt = S_EN_LO;
      S_EN_LO:   if (w_cnt_last) w_state_nxt = w_rom_more ? S_INIT_LD : S_IDLE;
      S_IDLE:    if (w_accept) w_state_nxt = S_EN_HI;
      default:   w_state_nxt = S_PWRUP;
    endcase
  end

  // Output decode: strobe, busy and the combinational ready handshake
  always_comb begin
    w_en     = (r_state == S_EN_HI);
    w_busy   = (r_state != S_IDLE);
    w_ready0 = (r_state == S_IDLE) & r_init_done & bus.valid0 & w_sel0;
    w_ready1 = (r_state == S_IDLE) & r_init_done & bus.valid1 & w_sel1;
  end

  // Dwell counter, ROM index, latched bus byte and arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rom_idx   <= 2'd0;
      r_data      <= 8'd0;
      r_rs        <= 1'b0;
      r_init_done <= 1'b0;
      r_grant     <= 1'b0;
      r_rr        <= 1'b0;
    end else begin
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state != S_IDLE)
        r_cnt <= r_cnt + cnt_t'(1);

      case (r_state)
        S_INIT_LD: begin
          r_data <= init_rom(r_rom_idx);
          r_rs   <= 1'b0;
        end
        S_EN_LO: begin
          if (w_cnt_last) begin
            if (w_rom_more) r_rom_idx   <= r_rom_idx + 2'd1;
            else            r_init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= w_ready1 ? bus.data1 : bus.data0;
            r_rs    <= w_ready1 ? bus.rs1   : bus.rs0;
            r_grant <= w_ready1;
            r_rr    <= ~w_ready1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.RS        = r_rs;
  assign bus.RW        = 1'b0;
  assign bus.EN        = w_en;
  assign bus.busy      = w_busy;
  assign bus.init_done = r_init_done;
  assign bus.grant     = r_grant;
  assign bus.ready0    = w_ready0;
  assign bus.ready1    = w_ready1;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with short timing parameters.
module tb_lcd_bus_arbiter;
  localparam int EH    = 2;
  localparam int CW    = 4;
  localparam int LW    = 10;
  localparam int PW    = 20;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_arbiter_if bus_if();

  lcd_bus_arbiter #(
    .EN_HIGH_CYC  (EH),
    .CMD_WAIT_CYC (CW),
    .LONG_WAIT_CYC(LW),
    .PWRUP_CYC    (PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts at a sample where EN=1. Counts the high samples and then the low busy samples.
  // Returns when EN rises again or the arbiter reaches IDLE.
  task automatic pulse(output int hi, output int lo, output int unstable, output int rdy_bad);
    logic [7:0] d0;
    logic       r0;
    d0 = bus_if.data;
    r0 = bus_if.RS;
    hi = 0; lo = 0; unstable = 0; rdy_bad = 0;
    while (bus_if.EN === 1'b1 && hi < LIMIT) begin
      if (bus_if.data !== d0 || bus_if.RS !== r0) unstable++;
      if (bus_if.ready0 === 1'b1 || bus_if.ready1 === 1'b1) rdy_bad++;
      hi++;
      tick();
    end
    while (bus_if.EN === 1'b0 && bus_if.busy === 1'b1 && lo < LIMIT) begin
      if (bus_if.ready0 === 1'b1 || bus_if.ready1 === 1'b1) rdy_bad++;
      lo++;
      tick();
    end
  endtask

  // Waits for a ready and passes through the accepting edge.
  task automatic wait_accept(output int who);
    int n;
    bit got;
    #1;
    who = -1; n = 0; got = 0;
    while (!got && n < LIMIT) begin
      if (bus_if.ready0 === 1'b1 || bus_if.ready1 === 1'b1) begin
        chk("ready_onehot", {31'd0, bus_if.ready0 & bus_if.ready1}, 32'd0);
        who = (bus_if.ready1 === 1'b1) ? 1 : 0;
        got = 1;
      end
      tick();
      n++;
    end
    if (!got) chk("accept_timeout", 32'(n), 32'(LIMIT + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rom_exp [4];
    int         gap_exp [4];
    int         exp_who [4];
    int         n, rdy_seen, hi, lo, unst, rbad, who;

    rom_exp = '{8'h38, 8'h0C, 8'h01, 8'h06};
    // Between init pulses the low time also includes the one-cycle ROM load.
    gap_exp = '{CW + 1, CW + 1, LW + 1, CW};
    exp_who = '{0, 1, 0, 1};

    bus_if.valid0 = 1'b1; bus_if.rs0 = 1'b1; bus_if.data0 = 8'h11;
    bus_if.valid1 = 1'b1; bus_if.rs1 = 1'b1; bus_if.data1 = 8'h22;

    // Reset state, with both requesters already valid
    rst = 1'b1;
    tick(); tick();
    chk("rst_data",  32'(bus_if.data), 32'h0);
    chk("rst_RS",    32'(bus_if.RS), 32'h0);
    chk("rst_RW",    32'(bus_if.RW), 32'h0);
    chk("rst_EN",    32'(bus_if.EN), 32'h0);
    chk("rst_busy",  32'(bus_if.busy), 32'h1);
    chk("rst_idone", 32'(bus_if.init_done), 32'h0);
    chk("rst_grant", 32'(bus_if.grant), 32'h0);
    chk("rst_ready", 32'({bus_if.ready1, bus_if.ready0}), 32'h0);

    // Power-up: PW cycles, then one ROM-load cycle before EN rises.
    rst = 1'b0;
    n = 0; rdy_seen = 0;
    while (bus_if.EN !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
      if (bus_if.ready0 === 1'b1 || bus_if.ready1 === 1'b1) rdy_seen++;
    end
    chk("pwrup_to_en", 32'(n), 32'(PW + 1));

    for (int k = 0; k < 4; k++) begin
      chk("init_data", 32'(bus_if.data), 32'(rom_exp[k]));
      chk("init_RS", 32'(bus_if.RS), 32'h0);
      pulse(hi, lo, unst, rbad);
      rdy_seen += rbad;
      chk("init_hi", 32'(hi), 32'(EH));
      chk("init_gap", 32'(lo), 32'(gap_exp[k]));
      chk("init_stable", 32'(unst), 32'h0);
    end
    chk("init_ready_quiet", 32'(rdy_seen), 32'h0);
    chk("init_done", 32'(bus_if.init_done), 32'h1);
    chk("init_idle", 32'(bus_if.busy), 32'h0);
    bus_if.valid0 = 1'b0;
    bus_if.valid1 = 1'b0;

    // Single write from requester 0
    bus_if.valid0 = 1'b1; bus_if.rs0 = 1'b1; bus_if.data0 = 8'h41;
    #1;
    chk("single_ready0", 32'(bus_if.ready0), 32'h1);
    chk("single_ready1", 32'(bus_if.ready1), 32'h0);
    tick();
    bus_if.valid0 = 1'b0;
    chk("single_EN", 32'(bus_if.EN), 32'h1);
    chk("single_data", 32'(bus_if.data), 32'h41);
    chk("single_RS", 32'(bus_if.RS), 32'h1);
    chk("single_grant", 32'(bus_if.grant), 32'h0);
    chk("single_ready_drop", 32'(bus_if.ready0), 32'h0);
    pulse(hi, lo, unst, rbad);
    chk("single_hi", 32'(hi), 32'(EH));
    chk("single_lo", 32'(lo), 32'(CW));
    chk("single_idle", 32'(bus_if.busy), 32'h0);
    chk("single_data_hold", 32'(bus_if.data), 32'h41);

    // Long command (clear) from requester 1, then a normal command
    bus_if.valid1 = 1'b1; bus_if.rs1 = 1'b0; bus_if.data1 = 8'h01;
    wait_accept(who);
    bus_if.valid1 = 1'b0;
    chk("long_who", 32'(who), 32'h1);
    chk("long_data", 32'(bus_if.data), 32'h01);
    chk("long_RS", 32'(bus_if.RS), 32'h0);
    chk("long_grant", 32'(bus_if.grant), 32'h1);
    pulse(hi, lo, unst, rbad);
    chk("long_hi", 32'(hi), 32'(EH));
    chk("long_lo", 32'(lo), 32'(LW));

    bus_if.valid1 = 1'b1; bus_if.rs1 = 1'b0; bus_if.data1 = 8'h80;
    wait_accept(who);
    bus_if.valid1 = 1'b0;
    chk("cmd80_data", 32'(bus_if.data), 32'h80);
    pulse(hi, lo, unst, rbad);
    chk("cmd80_lo", 32'(lo), 32'(CW));

    // Contention: the pointer is at requester 0 after the requester-1 grants.
    bus_if.valid0 = 1'b1; bus_if.rs0 = 1'b1; bus_if.data0 = 8'hA0;
    bus_if.valid1 = 1'b1; bus_if.rs1 = 1'b1; bus_if.data1 = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      wait_accept(who);
      chk("rr_who", 32'(who), 32'(exp_who[i]));
      chk("rr_ready_pulse", 32'({bus_if.ready1, bus_if.ready0}), 32'h0);
      chk("rr_data", 32'(bus_if.data), (exp_who[i] == 1) ? 32'hB1 : 32'hA0);
      chk("rr_grant", 32'(bus_if.grant), 32'(exp_who[i]));
      pulse(hi, lo, unst, rbad);
      chk("rr_lo", 32'(lo), 32'(CW));
    end
    bus_if.valid0 = 1'b0;
    bus_if.valid1 = 1'b0;

    // Backpressure: requester 0 raises valid during a requester-1 strobe
    bus_if.valid1 = 1'b1; bus_if.rs1 = 1'b1; bus_if.data1 = 8'h33;
    wait_accept(who);
    bus_if.valid1 = 1'b0;
    chk("bp_who", 32'(who), 32'h1);
    bus_if.valid0 = 1'b1; bus_if.rs0 = 1'b1; bus_if.data0 = 8'h55;
    #1;
    n = 0; rdy_seen = 0;
    while (bus_if.busy === 1'b1 && n < LIMIT) begin
      if (bus_if.ready0 === 1'b1) rdy_seen++;
      tick();
      n++;
    end
    chk("bp_ready_held", 32'(rdy_seen), 32'h0);
    chk("bp_busy_cycles", 32'(n), 32'(EH + CW));
    chk("bp_ready_idle", 32'(bus_if.ready0), 32'h1);
    tick();
    bus_if.valid0 = 1'b0;
    chk("bp_data", 32'(bus_if.data), 32'h55);
    chk("bp_grant", 32'(bus_if.grant), 32'h0);
    chk("bp_EN", 32'(bus_if.EN), 32'h1);

    // Reset while EN is high, then a full re-init
    rst = 1'b1;
    tick();
    chk("mid_rst_EN", 32'(bus_if.EN), 32'h0);
    chk("mid_rst_idone", 32'(bus_if.init_done), 32'h0);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'h1);
    chk("mid_rst_data", 32'(bus_if.data), 32'h0);
    rst = 1'b0;
    n = 0;
    while (bus_if.EN !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    chk("reinit_to_en", 32'(n), 32'(PW + 1));
    chk("reinit_data", 32'(bus_if.data), 32'h38);
    chk("reinit_RS", 32'(bus_if.RS), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
